// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU between NREQ requesters.
// One operation in flight at a time; the result is held until its owner consumes it.
module alu_arbiter #(
    parameter int NREQ    = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][31:0] req_instr,
    input  logic [NREQ-1:0][31:0] req_op1,
    input  logic [NREQ-1:0][31:0] req_op2,
    input  logic [NREQ-1:0][31:0] req_pc,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [31:0]           rsp_result,
    output logic                  alu_enable,
    output logic [31:0]           alu_instr,
    output logic [31:0]           alu_op1,
    output logic [31:0]           alu_op2,
    output logic [31:0]           alu_pc,
    input  logic [31:0]           alu_result,
    output logic                  busy
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state_r;
    logic [GW-1:0]   last_grant_r;
    logic [GW-1:0]   owner_r;
    logic [2:0]      cnt_r;
    logic [31:0]     instr_r;
    logic [31:0]     op1_r;
    logic [31:0]     op2_r;
    logic [31:0]     pc_r;
    logic [31:0]     result_r;
    logic [NREQ-1:0] rsp_valid_r;
    logic            alu_enable_r;
    logic            busy_r;

    logic [GW-1:0]   grant_s;
    logic            grant_vld_s;

    // Round-robin search starting one past the last winner, wrapping.
    always_comb begin
        int      nxt;
        logic [GW-1:0] idx;
        logic    hit;
        grant_s     = '0;
        grant_vld_s = 1'b0;
        nxt         = 0;
        idx         = '0;
        hit         = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            nxt         = int'(last_grant_r) + i + 1;
            idx         = GW'((nxt >= NREQ) ? (nxt - NREQ) : nxt);
            hit         = !grant_vld_s && req_valid[idx];
            grant_s     = hit ? idx : grant_s;
            grant_vld_s = grant_vld_s || hit;
        end
    end

    // Ready is offered only to the current winner while idle and out of reset.
    always_comb begin
        if ((state_r == IDLE) && grant_vld_s && rst_n) begin
            req_ready = ONE_HOT0 << grant_s;
        end else begin
            req_ready = '0;
        end
    end

    // Issue sequencing: accept, pulse the ALU, count out its latency, hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= GW'(NREQ - 1);
            owner_r      <= '0;
            cnt_r        <= 3'd0;
            instr_r      <= 32'd0;
            op1_r        <= 32'd0;
            op2_r        <= 32'd0;
            pc_r         <= 32'd0;
            result_r     <= 32'd0;
            rsp_valid_r  <= '0;
            alu_enable_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_vld_s) begin
                        instr_r      <= req_instr[grant_s];
                        op1_r        <= req_op1[grant_s];
                        op2_r        <= req_op2[grant_s];
                        pc_r         <= req_pc[grant_s];
                        owner_r      <= grant_s;
                        last_grant_r <= grant_s;
                        alu_enable_r <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= EXEC;
                    end else begin
                        alu_enable_r <= 1'b0;
                        busy_r       <= 1'b0;
                    end
                end
                EXEC: begin
                    alu_enable_r <= 1'b0;
                    cnt_r        <= 3'(ALU_LAT);
                    state_r      <= WAIT;
                end
                WAIT: begin
                    if (cnt_r <= 3'd1) begin
                        cnt_r       <= 3'd0;
                        result_r    <= alu_result;
                        rsp_valid_r <= ONE_HOT0 << owner_r;
                        state_r     <= RESP;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready[owner_r]) begin
                        rsp_valid_r <= '0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        rsp_valid_r <= rsp_valid_r;
                    end
                end
                default: begin
                    rsp_valid_r  <= '0;
                    alu_enable_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = result_r;
    assign alu_enable = alu_enable_r;
    assign alu_instr  = instr_r;
    assign alu_op1    = op1_r;
    assign alu_op2    = op2_r;
    assign alu_pc     = pc_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized phase,
// checked against a transaction-level timeline model and a latency-modelled ALU.
module tb_alu_arbiter;

    localparam int NREQ = 4;
    localparam int L    = 3;

    localparam logic [31:0] OP_ADD = 32'd0;
    localparam logic [31:0] OP_SUB = 32'd1;
    localparam logic [31:0] OP_XOR = 32'd2;
    localparam logic [31:0] OP_AND = 32'd3;
    localparam logic [31:0] OP_OR  = 32'd4;
    localparam logic [31:0] OP_SLL = 32'd5;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][31:0] req_instr;
    logic [NREQ-1:0][31:0] req_op1;
    logic [NREQ-1:0][31:0] req_op2;
    logic [NREQ-1:0][31:0] req_pc;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [31:0]           rsp_result;
    logic                  alu_enable;
    logic [31:0]           alu_instr, alu_op1, alu_op2, alu_pc;
    logic [31:0]           alu_result;
    logic                  busy;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ), .ALU_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_instr(req_instr), .req_op1(req_op1), .req_op2(req_op2), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .alu_enable(alu_enable), .alu_instr(alu_instr), .alu_op1(alu_op1),
        .alu_op2(alu_op2), .alu_pc(alu_pc), .alu_result(alu_result), .busy(busy)
    );

    function automatic logic [31:0] alu_fn(logic [31:0] ins, logic [31:0] a, logic [31:0] b);
        case (ins[2:0])
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a ^ b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a << b[4:0];
            default: return a;
        endcase
    endfunction

    // Stand-in ALU: result valid exactly L cycles after the enable cycle, garbage otherwise.
    logic [31:0] pv [L];
    bit          pok[L];
    always @(posedge clk) begin
        pv[0]  <= alu_fn(alu_instr, alu_op1, alu_op2);
        pok[0] <= alu_enable;
        for (int i = 1; i < L; i++) begin
            pv[i]  <= pv[i-1];
            pok[i] <= pok[i-1];
        end
    end
    assign alu_result = pok[L-1] ? pv[L-1] : 32'hDEAD_BEEF;

    int n_checks = 0;
    int n_fail   = 0;

    // Timeline model: m_age = 0 idle, else cycles since the accepting edge.
    int          m_age = 0;
    int          last  = NREQ - 1;
    int          owner;
    logic [31:0] exp_res, s_instr, s_op1, s_op2, s_pc;
    bit          acc_now, done_now;
    int          rsp_lat;
    int          acc_q[$];
    int          srv_q[$];
    logic [31:0] res_q[$];

    bit              pend[NREQ];
    logic [31:0]     p_instr[NREQ], p_op1[NREQ], p_op2[NREQ], p_pc[NREQ];
    bit              keep, rnd_req, rnd_ready;
    logic [NREQ-1:0] rdy_mask;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick(logic [NREQ-1:0] v, int lst);
        int best, bestd, d;
        best  = -1;
        bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - lst - 1 + 2 * NREQ) % NREQ;
            if (v[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic newreq(int i, logic [31:0] ins, logic [31:0] a, logic [31:0] b);
        pend[i]    = 1'b1;
        p_instr[i] = ins;
        p_op1[i]   = a;
        p_op2[i]   = b;
        p_pc[i]    = 32'h1000 + 32'(i * 4);
    endtask

    task automatic clear_q();
        acc_q.delete();
        srv_q.delete();
        res_q.delete();
    endtask

    task automatic observe();
        int g;
        acc_now  = 1'b0;
        done_now = 1'b0;
        if (m_age == 0) begin
            g = pick(req_valid, last);
            chk("busy_idle", 32'(busy), 32'd0);
            chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            chk("alu_en_idle", 32'(alu_enable), 32'd0);
            chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
            if (g >= 0) begin
                owner   = g;
                s_instr = req_instr[g];
                s_op1   = req_op1[g];
                s_op2   = req_op2[g];
                s_pc    = req_pc[g];
                exp_res = alu_fn(s_instr, s_op1, s_op2);
                acc_q.push_back(g);
                acc_now = 1'b1;
                if (!keep) pend[g] = 1'b0;
            end
        end else begin
            chk("busy_act", 32'(busy), 32'd1);
            chk("req_ready_act", 32'(req_ready), 32'd0);
            chk("alu_en", 32'(alu_enable), 32'(m_age == 1));
            chk("alu_instr", alu_instr, s_instr);
            chk("alu_op1", alu_op1, s_op1);
            chk("alu_op2", alu_op2, s_op2);
            chk("alu_pc", alu_pc, s_pc);
            if (m_age >= L + 2) begin
                chk("rsp_valid", 32'(rsp_valid), 32'd1 << owner);
                chk("rsp_result", rsp_result, exp_res);
                if (m_age == L + 2) rsp_lat = m_age;
                if (rsp_ready[owner]) begin
                    done_now = 1'b1;
                    srv_q.push_back(owner);
                    res_q.push_back(rsp_result);
                end
            end else begin
                chk("rsp_valid_early", 32'(rsp_valid), 32'd0);
            end
        end
    endtask

    // One clock: called and returns at posedge+2.
    task automatic run_cycle();
        if (rnd_req) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0)
                    newreq(i, $urandom, $urandom, $urandom);
                else if (pend[i] && $urandom_range(0, 31) == 0)
                    pend[i] = 1'b0;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = pend[i];
            req_instr[i] = p_instr[i];
            req_op1[i]   = p_op1[i];
            req_op2[i]   = p_op2[i];
            req_pc[i]    = p_pc[i];
        end
        rsp_ready = rnd_ready ? NREQ'($urandom) : rdy_mask;
        #2;
        observe();
        @(posedge clk);
        #2;
        if (m_age == 0) begin
            if (acc_now) begin
                m_age = 1;
                last  = owner;
            end
        end else if (done_now) begin
            m_age = 0;
        end else begin
            m_age++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_alu_en", 32'(alu_enable), 32'd0);
        chk("rst_alu_instr", alu_instr, 32'd0);
        chk("rst_alu_op1", alu_op1, 32'd0);
        chk("rst_alu_op2", alu_op2, 32'd0);
        chk("rst_alu_pc", alu_pc, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        m_age = 0;
        last  = NREQ - 1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bit third;
        rst_n     = 1'b0;
        req_valid = '0;
        req_instr = '0;
        req_op1   = '0;
        req_op2   = '0;
        req_pc    = '0;
        rsp_ready = '0;
        keep = 1'b0; rnd_req = 1'b0; rnd_ready = 1'b0; rdy_mask = '1;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            p_instr[i] = 32'd0; p_op1[i] = 32'd0; p_op2[i] = 32'd0; p_pc[i] = 32'd0;
        end
        @(posedge clk);
        #2;
        do_reset();

        // Single request from requester 0
        clear_q();
        newreq(0, OP_ADD, 32'd3, 32'd4);
        repeat (10) run_cycle();
        chk("single_count", 32'(srv_q.size()), 32'd1);
        chk("single_result", res_q[0], 32'd7);
        chk("single_latency", 32'(rsp_lat), 32'(L + 2));

        // Contention between 0 and 1, then a third request from 0
        do_reset();
        clear_q();
        third = 1'b0;
        newreq(0, OP_XOR, 32'hAAAA5555, 32'h5555AAAA);
        newreq(1, OP_AND, 32'hFFFF0000, 32'h0F0F0F0F);
        for (int k = 0; k < 40; k++) begin
            run_cycle();
            if (srv_q.size() == 1 && !third) begin
                newreq(0, OP_ADD, 32'd1, 32'd2);
                third = 1'b1;
            end
        end
        chk("cont_count", 32'(srv_q.size()), 32'd3);
        chk("cont_order0", 32'(srv_q[0]), 32'd0);
        chk("cont_order1", 32'(srv_q[1]), 32'd1);
        chk("cont_order2", 32'(srv_q[2]), 32'd0);
        chk("cont_res0", res_q[0], 32'hFFFFFFFF);
        chk("cont_res1", res_q[1], 32'h0F0F0000);
        chk("cont_res2", res_q[2], 32'd3);

        // Backpressure on requester 1 with another requester waiting
        clear_q();
        rdy_mask = 4'b1101;
        newreq(1, OP_OR, 32'h12, 32'h30);
        c = 0;
        while (m_age < L + 2 && c < 20) begin
            run_cycle();
            c++;
        end
        chk("bp_reach_resp", 32'(m_age >= L + 2), 32'd1);
        newreq(0, OP_SUB, 32'd50, 32'd8);
        repeat (10) run_cycle();
        chk("bp_held", 32'(srv_q.size()), 32'd0);
        rdy_mask = '1;
        repeat (12) run_cycle();
        chk("bp_count", 32'(srv_q.size()), 32'd2);
        chk("bp_res1", res_q[0], 32'h32);
        chk("bp_res0", res_q[1], 32'd42);

        // Reset in the second WAIT cycle
        clear_q();
        newreq(2, OP_SUB, 32'd10, 32'd3);
        c = 0;
        while (m_age != 3 && c < 20) begin
            run_cycle();
            c++;
        end
        chk("rw_reach_wait", 32'(m_age), 32'd3);
        do_reset();
        clear_q();
        repeat (8) run_cycle();
        chk("rw_no_rsp", 32'(srv_q.size()), 32'd0);
        newreq(1, OP_ADD, 32'd5, 32'd6);
        newreq(3, OP_ADD, 32'd7, 32'd8);
        newreq(0, OP_ADD, 32'd9, 32'd1);
        repeat (25) run_cycle();
        chk("rw_first_grant", 32'(acc_q[0]), 32'd0);
        chk("rw_served", 32'(srv_q.size()), 32'd3);

        // Latency with SLL
        clear_q();
        newreq(3, OP_SLL, 32'd1, 32'd4);
        repeat (10) run_cycle();
        chk("sll_result", res_q[0], 32'd16);
        chk("sll_latency", 32'(rsp_lat), 32'd5);

        // Fairness with all requesters continuously valid
        do_reset();
        clear_q();
        keep = 1'b1;
        for (int i = 0; i < NREQ; i++) newreq(i, OP_ADD, 32'(i), 32'(i));
        repeat (40) run_cycle();
        chk("fair_count", 32'(acc_q.size() >= 6), 32'd1);
        for (int k = 0; k < 6; k++) chk("fair_order", 32'(acc_q[k]), 32'(k % NREQ));
        keep = 1'b0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        repeat (10) run_cycle();

        // Randomized traffic with random response backpressure
        clear_q();
        rnd_req   = 1'b1;
        rnd_ready = 1'b1;
        repeat (600) run_cycle();
        rnd_req   = 1'b0;
        rnd_ready = 1'b0;
        rdy_mask  = '1;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        repeat (20) run_cycle();
        chk("rnd_drained", 32'(m_age), 32'd0);
        chk("rnd_acc_vs_srv", 32'(srv_q.size()), 32'(acc_q.size()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
